// File: rtl/painterengine_gpu_dma_writer_pkg.sv
// Shared definitions for the GPU DMA writer/reader pair: FSM encoding,
// default geometry and the fixed AXI4 attribute values.
package painterengine_gpu_dma_writer_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_ADDRESS_WIDTH = 32;
  localparam int DEFAULT_DATA_ALIGN    = 64;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_AWCACHE    = 4'b0010;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_ADDR  = 3'b001,
    ST_DATA  = 3'b010,
    ST_RESP  = 3'b011,
    ST_DONE  = 3'b100,
    ST_ERROR = 3'b111
  } state_e;

endpackage

// File: rtl/painterengine_gpu_burst_calc.sv
// Burst length = min(words left before the next ALIGN boundary, words left
// in the transfer). Purely combinational; also used by the DMA reader.
module painterengine_gpu_burst_calc
  import painterengine_gpu_dma_writer_pkg::*;
#(
  parameter int PARAM_DATA_ALIGN = DEFAULT_DATA_ALIGN
) (
  input  logic [15:0] word_index,
  input  logic [31:0] remaining,
  output logic [15:0] burst
);

  localparam logic [15:0] ALIGN = 16'(PARAM_DATA_ALIGN);

  logic [15:0] boundary_left;

  // ALIGN is a power of two, so the mask gives the position inside the window.
  assign boundary_left = ALIGN - (word_index & (ALIGN - 16'd1));
  assign burst         = (remaining < {16'd0, boundary_left}) ? remaining[15:0] : boundary_left;

endmodule

// File: rtl/painterengine_gpu_dma_writer.sv
// AXI4 write master: streams source words to memory as boundary-safe INCR
// bursts, one burst outstanding, ending in a terminal DONE or ERROR state.
module painterengine_gpu_dma_writer
  import painterengine_gpu_dma_writer_pkg::*;
#(
  parameter int PARAM_DATA_ALIGN    = DEFAULT_DATA_ALIGN,
  parameter int PARAM_ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int PARAM_DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                             i_wire_clock,
  input  logic                             i_wire_resetn,
  input  logic [PARAM_ADDRESS_WIDTH-1:0]   i_wire_address,
  input  logic [31:0]                      i_wire_length,
  input  logic [PARAM_DATA_WIDTH-1:0]      i_wire_data,
  input  logic                             i_wire_data_valid,
  output logic                             o_wire_data_next,
  output logic                             o_wire_done,
  output logic                             o_wire_error,
  output logic                             o_wire_M_AXI_AWID,
  output logic [PARAM_ADDRESS_WIDTH-1:0]   o_wire_M_AXI_AWADDR,
  output logic [7:0]                       o_wire_M_AXI_AWLEN,
  output logic [2:0]                       o_wire_M_AXI_AWSIZE,
  output logic [1:0]                       o_wire_M_AXI_AWBURST,
  output logic                             o_wire_M_AXI_AWLOCK,
  output logic [3:0]                       o_wire_M_AXI_AWCACHE,
  output logic [2:0]                       o_wire_M_AXI_AWPROT,
  output logic [3:0]                       o_wire_M_AXI_AWQOS,
  output logic                             o_wire_M_AXI_AWVALID,
  input  logic                             i_wire_M_AXI_AWREADY,
  output logic [PARAM_DATA_WIDTH-1:0]      o_wire_M_AXI_WDATA,
  output logic [PARAM_DATA_WIDTH/8-1:0]    o_wire_M_AXI_WSTRB,
  output logic                             o_wire_M_AXI_WLAST,
  output logic                             o_wire_M_AXI_WVALID,
  input  logic                             i_wire_M_AXI_WREADY,
  input  logic                             i_wire_M_AXI_BID,
  input  logic [1:0]                       i_wire_M_AXI_BRESP,
  input  logic                             i_wire_M_AXI_BVALID,
  output logic                             o_wire_M_AXI_BREADY
);

  localparam int AW = PARAM_ADDRESS_WIDTH;

  state_e        state, state_next;
  logic [AW-1:0] addr_reg, addr_next, awaddr_reg, awaddr_next;
  logic [31:0]   len_reg, len_next, offset, offset_next, offset_sum;
  logic [15:0]   burst, burst_next, beat, beat_next, timeout, timeout_next;
  logic [7:0]    awlen_reg, awlen_next;
  logic [15:0]   calc_index, calc_burst;
  logic [31:0]   calc_remaining;
  logic          aw_hs, w_hs, b_hs;
  logic          unused_bid;

  assign unused_bid = i_wire_M_AXI_BID;

  assign o_wire_M_AXI_AWID    = 1'b0;
  assign o_wire_M_AXI_AWSIZE  = AXI_SIZE_4B;
  assign o_wire_M_AXI_AWBURST = AXI_BURST_INCR;
  assign o_wire_M_AXI_AWLOCK  = 1'b0;
  assign o_wire_M_AXI_AWCACHE = AXI_AWCACHE;
  assign o_wire_M_AXI_AWPROT  = 3'b000;
  assign o_wire_M_AXI_AWQOS   = 4'b0000;
  assign o_wire_M_AXI_WSTRB   = '1;
  assign o_wire_M_AXI_AWADDR  = awaddr_reg;
  assign o_wire_M_AXI_AWLEN   = awlen_reg;
  assign o_wire_M_AXI_WDATA   = i_wire_data;

  // Valids derive from state, so an async reset clears them in the same instant.
  assign o_wire_M_AXI_AWVALID = (state == ST_ADDR);
  assign o_wire_M_AXI_WVALID  = (state == ST_DATA) && i_wire_data_valid;
  assign o_wire_M_AXI_WLAST   = o_wire_M_AXI_WVALID && (beat == burst - 16'd1);
  assign o_wire_M_AXI_BREADY  = (state == ST_RESP);
  assign o_wire_done          = (state == ST_DONE);
  assign o_wire_error         = (state == ST_ERROR);

  assign aw_hs            = o_wire_M_AXI_AWVALID && i_wire_M_AXI_AWREADY;
  assign w_hs             = o_wire_M_AXI_WVALID && i_wire_M_AXI_WREADY;
  assign b_hs             = o_wire_M_AXI_BREADY && i_wire_M_AXI_BVALID;
  assign o_wire_data_next = w_hs;

  // The calculator sees the fresh request in IDLE and the next burst in RESP.
  assign offset_sum     = offset + 32'(burst);
  assign calc_index     = (state == ST_RESP) ? (16'(addr_reg[AW-1:2]) + offset_sum[15:0])
                                             : 16'(i_wire_address[AW-1:2]);
  assign calc_remaining = (state == ST_RESP) ? (len_reg - offset_sum) : i_wire_length;

  painterengine_gpu_burst_calc #(
    .PARAM_DATA_ALIGN(PARAM_DATA_ALIGN)
  ) u_burst_calc (
    .word_index(calc_index),
    .remaining (calc_remaining),
    .burst     (calc_burst)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_next   = state;
    addr_next    = addr_reg;
    len_next     = len_reg;
    offset_next  = offset;
    burst_next   = burst;
    beat_next    = beat;
    awaddr_next  = awaddr_reg;
    awlen_next   = awlen_reg;
    timeout_next = '0;

    unique case (state)
      ST_IDLE: begin
        if (i_wire_address[1:0] != 2'b00 || i_wire_length == 32'd0) begin
          state_next = ST_ERROR;
        end else begin
          addr_next   = i_wire_address;
          len_next    = i_wire_length;
          offset_next = '0;
          awaddr_next = i_wire_address;
          burst_next  = calc_burst;
          awlen_next  = 8'(calc_burst - 16'd1);
          state_next  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (i_wire_M_AXI_AWREADY) begin
          beat_next  = '0;
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          if (beat == burst - 16'd1) state_next = ST_RESP;
          else                       beat_next  = beat + 16'd1;
        end
      end
      ST_RESP: begin
        if (i_wire_M_AXI_BVALID) begin
          if (i_wire_M_AXI_BRESP != AXI_RESP_OKAY) begin
            state_next = ST_ERROR;
          end else begin
            offset_next = offset_sum;
            if (offset_sum >= len_reg) begin
              state_next = ST_DONE;
            end else begin
              awaddr_next = addr_reg + (AW'(offset_sum) << 2);
              burst_next  = calc_burst;
              awlen_next  = 8'(calc_burst - 16'd1);
              state_next  = ST_ADDR;
            end
          end
        end
      end
      default: state_next = state;
    endcase

    // Any stalled channel counts towards the watchdog; any handshake rearms it.
    if (state == ST_ADDR || state == ST_DATA || state == ST_RESP) begin
      if (!(aw_hs || w_hs || b_hs)) begin
        timeout_next = timeout + 16'd1;
        if (timeout_next == 16'hFFFF) state_next = ST_ERROR;
      end
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state      <= ST_IDLE;
      addr_reg   <= '0;
      len_reg    <= '0;
      offset     <= '0;
      burst      <= '0;
      beat       <= '0;
      timeout    <= '0;
      awaddr_reg <= '0;
      awlen_reg  <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state      <= state_next;
      addr_reg   <= addr_next;
      len_reg    <= len_next;
      offset     <= offset_next;
      burst      <= burst_next;
      beat       <= beat_next;
      timeout    <= timeout_next;
      awaddr_reg <= awaddr_next;
      awlen_reg  <= awlen_next;
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_dma_writer.sv
// Bench for the GPU DMA writer: a burst-list/data-sequence model of each
// transfer, a randomized AXI slave and source, and one negedge compare process.
module tb_painterengine_gpu_dma_writer;

  localparam int ALIGN = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address = '0, length = '0, src_data = '0;
  logic        src_valid = 1'b0;
  logic        data_next, done, error;
  logic        awid, awlock, awvalid, wlast, wvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [7:0]  awlen;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst;
  logic [3:0]  awcache, awqos, wstrb;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0]  bresp = 2'b00;

  always #5 clk = ~clk;

  painterengine_gpu_dma_writer dut (
    .i_wire_clock(clk), .i_wire_resetn(rst_n),
    .i_wire_address(address), .i_wire_length(length),
    .i_wire_data(src_data), .i_wire_data_valid(src_valid),
    .o_wire_data_next(data_next), .o_wire_done(done), .o_wire_error(error),
    .o_wire_M_AXI_AWID(awid), .o_wire_M_AXI_AWADDR(awaddr), .o_wire_M_AXI_AWLEN(awlen),
    .o_wire_M_AXI_AWSIZE(awsize), .o_wire_M_AXI_AWBURST(awburst), .o_wire_M_AXI_AWLOCK(awlock),
    .o_wire_M_AXI_AWCACHE(awcache), .o_wire_M_AXI_AWPROT(awprot), .o_wire_M_AXI_AWQOS(awqos),
    .o_wire_M_AXI_AWVALID(awvalid), .i_wire_M_AXI_AWREADY(awready),
    .o_wire_M_AXI_WDATA(wdata), .o_wire_M_AXI_WSTRB(wstrb), .o_wire_M_AXI_WLAST(wlast),
    .o_wire_M_AXI_WVALID(wvalid), .i_wire_M_AXI_WREADY(wready),
    .i_wire_M_AXI_BID(1'b0), .i_wire_M_AXI_BRESP(bresp), .i_wire_M_AXI_BVALID(bvalid),
    .o_wire_M_AXI_BREADY(bready)
  );

  int n_checks = 0, n_pass = 0;
  bit mon_en = 1'b0;

  // Model of the current transfer and progress as observed by the compare process.
  logic [31:0] exp_addr[$];
  int          exp_len[$];
  int          n_aw, exp_beats;
  int          aw_idx, w_burst, beat_in_burst, beat_total, pulses, b_hs_cnt;
  logic [31:0] obs_awaddr[$];
  int          obs_awlen[$];
  logic [31:0] word_seed;
  bit          wl_exp;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
  endtask

  function automatic logic [31:0] word_of(input int k);
    return (32'(k) * 32'h9E37_79B1) ^ word_seed;
  endfunction

  // Walk the transfer word by word-window: each burst stops at the next ALIGN boundary.
  task automatic build_model(input logic [31:0] addr, input logic [31:0] len);
    logic [31:0] off, wi, b;
    exp_addr.delete();
    exp_len.delete();
    if (addr[1:0] != 2'b00 || len == 0) return;
    off = 0;
    while (off < len) begin
      wi = (addr >> 2) + off;
      b  = ALIGN - (wi % ALIGN);
      if (b > len - off) b = len - off;
      exp_addr.push_back(addr + off * 4);
      exp_len.push_back(int'(b));
      off += b;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_ctrl", {awvalid, wvalid, wlast, bready, done, error, data_next}, 7'b0);
    check("rst_awaddr", awaddr, 32'h0);
    check("rst_awlen", awlen, 8'h0);
    check("const_aw", {awid, awsize, awburst, awlock, awcache, awprot, awqos},
          {1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000});
    check("const_wstrb", wstrb, 4'hF);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("data_next", data_next, wvalid && wready);
      if (data_next) pulses++;
      if (awvalid) begin
        check("aw_allowed", aw_idx < n_aw, 1'b1);
        if (awready && aw_idx < n_aw) begin
          check("awaddr", awaddr, exp_addr[aw_idx]);
          check("awlen", awlen, 8'(exp_len[aw_idx] - 1));
          obs_awaddr.push_back(awaddr);
          obs_awlen.push_back(int'(awlen));
          aw_idx++;
        end
      end
      if (wvalid) begin
        wl_exp = (w_burst < n_aw) && (beat_in_burst == exp_len[w_burst] - 1);
        check("wlast", wlast, wl_exp);
        if (wready) begin
          check("w_in_range", beat_total < exp_beats, 1'b1);
          check("wdata", wdata, word_of(beat_total));
          beat_total++;
          if (wl_exp) begin
            beat_in_burst = 0;
            w_burst++;
          end else begin
            beat_in_burst++;
          end
        end
      end else begin
        check("wlast_idle", wlast, 1'b0);
      end
      if (bvalid && bready) b_hs_cnt++;
    end
  end

  task automatic run_transfer(input logic [31:0] addr, input logic [31:0] len, input int err_burst,
                              input bit gaps, input bit stall_aw, input int abort_at, input int budget);
    int cycles = 0;
    int b_sent = 0;
    bit aborted = 1'b0;
    bit exp_err;
    mon_en = 1'b0;
    rst_n = 1'b0;
    awready = 1'b0; wready = 1'b0; src_valid = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    address = addr; length = len;
    word_seed = $urandom;
    src_data = word_of(0);
    build_model(addr, len);
    n_aw = (err_burst >= 0 && err_burst < exp_len.size()) ? err_burst + 1 : exp_len.size();
    exp_beats = 0;
    for (int i = 0; i < n_aw; i++) exp_beats += exp_len[i];
    exp_err = (exp_len.size() == 0) || (err_burst >= 0) || stall_aw;
    aw_idx = 0; w_burst = 0; beat_in_burst = 0; beat_total = 0; pulses = 0; b_hs_cnt = 0;
    obs_awaddr.delete();
    obs_awlen.delete();
    repeat (2) @(posedge clk);
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    while (!(done || error) && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      if (abort_at >= 0 && beat_total >= abort_at) begin
        mon_en = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_reset_outputs();
        aborted = 1'b1;
        break;
      end
      if (b_hs_cnt > b_sent) begin
        b_sent++;
        bvalid = 1'b0;
      end
      if (!bvalid && w_burst > b_sent && (!gaps || $urandom_range(1, 0) == 1)) begin
        bvalid = 1'b1;
        bresp  = (b_sent == err_burst) ? 2'b10 : 2'b00;
      end
      awready   = stall_aw ? 1'b0 : (!gaps || $urandom_range(3, 0) != 0);
      wready    = !gaps || $urandom_range(3, 0) != 0;
      src_valid = !gaps || $urandom_range(3, 0) != 0;
      src_data  = word_of(beat_total);
    end
    mon_en = 1'b0;
    if (!aborted) begin
      check("done", done, !exp_err);
      check("error", error, exp_err);
      check("aw_count", aw_idx, stall_aw ? 0 : n_aw);
      check("beats", beat_total, stall_aw ? 0 : exp_beats);
      check("data_next_pulses", pulses, stall_aw ? 0 : exp_beats);
      if (exp_len.size() == 0) check("early_error", cycles <= 2, 1'b1);
      if (stall_aw) check("timeout_window", cycles >= 65530 && cycles <= 65545, 1'b1);
    end
  endtask

  initial begin
    // Single 16-word burst, everything always ready.
    run_transfer(32'h1000_0000, 16, -1, 1'b0, 1'b0, -1, 2000);
    check("t1_aw_n", obs_awaddr.size(), 1);
    if (obs_awaddr.size() >= 1) begin
      check("t1_awaddr", obs_awaddr[0], 32'h1000_0000);
      check("t1_awlen", obs_awlen[0], 15);
    end

    // 4 words before the 64-word boundary, then 4 after it.
    run_transfer(32'h1000_00F0, 8, -1, 1'b0, 1'b0, -1, 2000);
    check("t2_aw_n", obs_awaddr.size(), 2);
    if (obs_awaddr.size() >= 2) begin
      check("t2_awaddr0", obs_awaddr[0], 32'h1000_00F0);
      check("t2_awlen0", obs_awlen[0], 3);
      check("t2_awaddr1", obs_awaddr[1], 32'h1000_0100);
      check("t2_awlen1", obs_awlen[1], 3);
    end

    // Rejected requests.
    run_transfer(32'h1000_0000, 0, -1, 1'b0, 1'b0, -1, 100);
    run_transfer(32'h1000_0002, 16, -1, 1'b0, 1'b0, -1, 100);

    // SLVERR on the first of two bursts.
    run_transfer(32'h1000_00F0, 8, 0, 1'b0, 1'b0, -1, 2000);
    check("t5_aw_n", obs_awaddr.size(), 1);

    // 130 words from 0 with random backpressure.
    run_transfer(32'h0000_0000, 130, -1, 1'b1, 1'b0, -1, 5000);
    check("t6_aw_n", obs_awlen.size(), 3);
    if (obs_awlen.size() >= 3) begin
      check("t6_awlen0", obs_awlen[0], 63);
      check("t6_awlen1", obs_awlen[1], 63);
      check("t6_awlen2", obs_awlen[2], 1);
      check("t6_awaddr2", obs_awaddr[2], 32'h0000_0200);
    end

    for (int i = 0; i < 6; i++) begin
      run_transfer($urandom & 32'hFFFF_FFFC, 32'($urandom_range(200, 1)), -1,
                   1'(($urandom_range(1, 0))), 1'b0, -1, 5000);
    end

    // Reset in the middle of a data phase, then a clean restart.
    run_transfer(32'h2000_0000, 64, -1, 1'b1, 1'b0, 10, 5000);
    run_transfer(32'h1000_0000, 16, -1, 1'b0, 1'b0, -1, 2000);
    check("restart_aw_n", obs_awaddr.size(), 1);

    // Address channel never ready: watchdog must fire.
    run_transfer(32'h0000_0000, 4, -1, 1'b0, 1'b1, -1, 70000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
